ram_burst_arbiter: RTL and testbench
====================================

// Module: ram_burst_arbiter
// PURPOSE
//  Shares the single-port 4096x32 data RAM between NUM_REQ requesters (core0, core1, ...).
//  Each requester issues burst commands (read or write, base address, length).
//  The arbiter grants whole bursts round-robin and generates the word-stepped RAM addresses.
//  It sits between the core load/store units and the data RAM; RAM reads are combinational.
// PARAMETERS
//  NUM_REQ    2    number of requesters (>=2)
//  ADDR_W     32   byte-address width
//  DATA_W     32   data width
//  MAX_BURST  16   max beats per burst; LEN_W = $clog2(MAX_BURST); cmd_len = beats-1
// PORTS
//  clk          in   1              clock
//  rstn         in   1              synchronous active-low reset
//  cmd_valid_i  in   NUM_REQ        per-requester command valid
//  cmd_we_i     in   NUM_REQ        1=write burst, 0=read burst
//  cmd_addr_i   in   NUM_REQ*ADDR_W byte base address; bits[1:0] ignored
//  cmd_len_i    in   NUM_REQ*LEN_W  beats-1
//  cmd_ready_o  out  NUM_REQ        one-hot command accept pulse
//  wvalid_i     in   NUM_REQ        write beat valid
//  wdata_i      in   NUM_REQ*DATA_W write beat data
//  wready_o     out  NUM_REQ        write beat ready (granted write burst only)
//  rvalid_o     out  NUM_REQ        read data valid, one-hot, no backpressure
//  rdata_o      out  DATA_W         read data, shared by all requesters
//  grant_o      out  NUM_REQ        one-hot owner of current burst, 0 in IDLE
//  busy_o       out  1              1 while in BURST
//  ram_req_o    out  1              RAM read request
//  ram_addr_o   out  ADDR_W         RAM byte address, word aligned
//  ram_we_o     out  1              RAM write enable
//  ram_wdata_o  out  DATA_W         RAM write data
//  ram_rdata_i  in   DATA_W         RAM read data, combinational from ram_addr_o
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - state=IDLE; all outputs 0; rr_ptr=NUM_REQ-1, so req0 has top priority first.
//   - A burst in progress is abandoned and any pending read response is dropped.
//  IDLE:
//   - RAM outputs 0.
//   - If any cmd_valid_i, winner w = first valid requester searching from rr_ptr+1 (mod NUM_REQ).
//   - cmd_ready_o[w]=1 combinationally in this cycle.
//   - At the edge: latch we_q, addr_q=addr&~3, len_q, gnt_q=w; cnt=0; rr_ptr=w; go BURST.
//   - Idle cycle between bursts is mandatory: max throughput is (len+1)/(len+2).
//  BURST, read (we_q=0):
//   - Every cycle: ram_req_o=1, ram_addr_o=addr_q.
//   - At the edge: rdata_o<=ram_rdata_i, rvalid_o[gnt_q]<=1; addr_q+=4; cnt++.
//   - Read latency: exactly 1 cycle, issue to rvalid_o.
//  BURST, write (we_q=1):
//   - wready_o[gnt_q]=1; ram_we_o=wvalid_i[gnt_q]; ram_addr_o=addr_q; ram_wdata_o=wdata_i[gnt_q].
//   - addr_q and cnt advance only on an accepted beat; with wvalid low the burst stalls
//     indefinitely and holds the grant.
//  Burst end:
//   - The beat with cnt==len_q is the last; the next state is IDLE.
//   - The final read response still appears (rvalid_o) in the first IDLE cycle.
//  Outputs:
//   - rvalid_o is 0 in any cycle without a response.
//   - rdata_o holds its last value when rvalid_o=0.
//  Boundary rules:
//   - addr_q wraps modulo 2^ADDR_W; no range checking.
//   - cmd_* of non-winners are ignored; requesters hold cmd_valid until cmd_ready.
//   - cmd_* of the winner are not sampled again after acceptance.
//   - New commands arriving during BURST wait; simultaneous requests are resolved by rr_ptr.
//   - wvalid_i of non-granted requesters has no effect.
//   - ram_we_o and ram_req_o are never both 1.
// TESTING
//  1. Reset, then req0 reads len=3 @0x10.
//     -> ram_addr 0x10,0x14,0x18,0x1C on consecutive cycles; rvalid_o[0] 4 cycles, each lagging by 1.
//  2. req1 writes len=1 @0x20, data A,B, with wvalid low for 2 cycles between beats.
//     -> ram_we only on valid beats; RAM[8]=A, RAM[9]=B; grant held through the stall.
//  3. Both cmd_valid asserted continuously, len=0.
//     -> grants alternate 0,1,0,1; each burst followed by one IDLE cycle.
//  4. Command with addr=0x13.
//     -> ram_addr_o=0x10; command with addr=0xFFFFFFFC, len=1 -> second beat at 0x0.
//  5. rstn=0 mid read burst.
//     -> next cycle all outputs 0, state IDLE; no further rvalid; req0 wins the next tie.
//  6. Write 0x5A5A5A5A @0x40, then read @0x40.
//     -> rdata_o=0x5A5A5A5A with rvalid_o one cycle after ram_req_o.

Source files
------------

// File: rtl/ram_burst_arbiter.sv
// Round-robin burst arbiter sharing one single-port data RAM between NUM_REQ requesters.
// Whole bursts are granted; word-stepped addresses are generated here and reads return one cycle later.

module ram_burst_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              gnt,
  input  logic              wr_burst,
  input  logic              wvalid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wready,
  output logic              beat,
  output logic [DATA_W-1:0] wdata_sel
);
  assign wready    = gnt & wr_burst;
  assign beat      = wready & wvalid;
  // Zeroed when not owner so the top can OR all lanes onto the RAM bus.
  assign wdata_sel = wready ? wdata : '0;
endmodule

module ram_burst_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        cmd_valid_i,
  input  logic [NUM_REQ-1:0]        cmd_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] cmd_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  cmd_len_i,
  output logic [NUM_REQ-1:0]        cmd_ready_o,
  input  logic [NUM_REQ-1:0]        wvalid_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        wready_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      ram_req_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_W-1:0]         ram_wdata_o,
  input  logic [DATA_W-1:0]         ram_rdata_i
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] cmd_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0]  cmd_len;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0][DATA_W-1:0] lane_wdata;
  logic [NUM_REQ-1:0]             lane_beat;
  logic [NUM_REQ-1:0]             gnt_oh;

  state_t            state, state_nxt;
  burst_t            burst;
  logic [LEN_W-1:0]  cnt;
  logic [IDX_W-1:0]  gnt_q, rr_ptr, win;
  logic              any_valid, busy, rd_issue, beat_acc, last_beat;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  assign cmd_addr  = cmd_addr_i;
  assign cmd_len   = cmd_len_i;
  assign wdata     = wdata_i;
  assign any_valid = |cmd_valid_i;
  assign busy      = (state == BURST);
  assign rd_issue  = busy & ~burst.we;
  assign beat_acc  = busy & (burst.we ? |lane_beat : 1'b1);
  assign last_beat = beat_acc & (cnt == burst.len);

  // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    win   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && cmd_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (busy) gnt_oh[gnt_q] = 1'b1;
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    ram_burst_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt       (gnt_oh[g]),
      .wr_burst  (burst.we),
      .wvalid    (wvalid_i[g]),
      .wdata     (wdata[g]),
      .wready    (wready_o[g]),
      .beat      (lane_beat[g]),
      .wdata_sel (lane_wdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = '0;
    grant_o     = gnt_oh;
    busy_o      = busy;
    ram_req_o   = rd_issue;
    ram_addr_o  = busy ? burst.addr : '0;
    ram_we_o    = |lane_beat;
    ram_wdata_o = '0;
    if (state == IDLE && any_valid) cmd_ready_o[win] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) ram_wdata_o = ram_wdata_o | lane_wdata[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      burst    <= '0;
      cnt      <= '0;
      gnt_q    <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        burst.we   <= cmd_we_i[win];
        burst.addr <= cmd_addr[win] & ~ADDR_W'(3);
        burst.len  <= cmd_len[win];
        gnt_q      <= win;
        rr_ptr     <= win;
        cnt        <= '0;
      end else if (beat_acc) begin
        burst.addr <= burst.addr + ADDR_W'(4);
        cnt        <= cnt + 1'b1;
      end
      // rdata_q keeps its last value between responses.
      rvalid_q <= rd_issue ? gnt_oh : '0;
      if (rd_issue) rdata_q <= ram_rdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Directed bench for ram_burst_arbiter: RAM model, read-response scoreboard, immediate assertions.

module tb_ram_burst_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      cmd_valid, cmd_we;
  logic [N-1:0][AW-1:0] cmd_addr;
  logic [N-1:0][LW-1:0] cmd_len;
  logic [N-1:0]      cmd_ready;
  logic [N-1:0]      wvalid;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0]      wready, rvalid, grant;
  logic [DW-1:0]     rdata, ram_wdata, ram_rdata;
  logic              busy, ram_req, ram_we;
  logic [AW-1:0]     ram_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]  rv;
    logic [DW-1:0] d;
  } rsp_t;
  rsp_t sb[$];

  logic [DW-1:0] mem [0:4095];
  bit            wr_flag [0:4095];

  always #5 clk = ~clk;

  ram_burst_arbiter dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid_i(cmd_valid), .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .cmd_ready_o(cmd_ready), .wvalid_i(wvalid), .wdata_i(wdata), .wready_o(wready),
    .rvalid_o(rvalid), .rdata_o(rdata), .grant_o(grant), .busy_o(busy),
    .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Unwritten words read back as a fixed address-derived pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hA000_0000 + {20'h0, a[13:2]};
  endfunction

  assign ram_rdata = wr_flag[ram_addr[13:2]] ? mem[ram_addr[13:2]] : pat(ram_addr);

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[13:2]]     <= ram_wdata;
      wr_flag[ram_addr[13:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    rsp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid", rvalid, e.rv);
      chk("rdata", rdata, e.d);
    end else begin
      chk("rvalid_quiet", rvalid, '0);
    end
  endtask

  task automatic cmd(input int r, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_valid[r] = 1'b1;
    cmd_we[r]    = we;
    cmd_addr[r]  = a;
    cmd_len[r]   = l;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ram_req"}, ram_req, 1'b0);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, '0);
    chk({tag, "_ram_wdata"}, ram_wdata, '0);
    chk({tag, "_wready"}, wready, '0);
    chk({tag, "_rvalid"}, rvalid, '0);
  endtask

  // Accept a read burst on requester r and check every beat address; responses go to the scoreboard.
  task automatic read_burst(input string tag, input int r, input logic [AW-1:0] a, input int len);
    logic [AW-1:0] ea;
    logic [N-1:0]  oh;
    oh = '0;
    oh[r] = 1'b1;
    cmd(r, 1'b0, a, LW'(len));
    #1;
    chk({tag, "_cmd_ready"}, cmd_ready, oh);
    tick();
    cmd_valid[r] = 1'b0;
    ea = a & ~32'h3;
    for (int b = 0; b <= len; b++) begin
      #1;
      chk({tag, "_ram_req"}, ram_req, 1'b1);
      chk({tag, "_ram_addr"}, ram_addr, ea);
      chk({tag, "_grant"}, grant, oh);
      sb.push_back('{rv: oh, d: pat(ea)});
      tick();
      ea = ea + 32'd4;
    end
    chk({tag, "_end_busy"}, busy, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = '0; cmd_we = '0; cmd_addr = '0; cmd_len = '0;
    wvalid = '0; wdata = '0;
    tick();
    tick();
    outputs_zero("reset");
    chk("reset_rdata", rdata, '0);
    rstn = 1'b1;
    tick();

    // Read burst len=3 from req0.
    read_burst("rd4", 0, 32'h10, 3);
    tick();

    // Write burst from req1 with a two-cycle stall between beats.
    cmd(1, 1'b1, 32'h20, 4'd1);
    #1;
    chk("wr_cmd_ready", cmd_ready, 2'b10);
    tick();
    cmd_valid = '0;
    wvalid[1] = 1'b1;
    wdata[1]  = 32'hAAAA_0001;
    #1;
    chk("wr_a_wready", wready, 2'b10);
    chk("wr_a_we", ram_we, 1'b1);
    chk("wr_a_req", ram_req, 1'b0);
    chk("wr_a_addr", ram_addr, 32'h20);
    chk("wr_a_data", ram_wdata, 32'hAAAA_0001);
    tick();
    wvalid[1] = 1'b0;
    wvalid[0] = 1'b1;
    wdata[0]  = 32'hDEAD_BEEF;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("wr_stall_we", ram_we, 1'b0);
      chk("wr_stall_grant", grant, 2'b10);
      chk("wr_stall_addr", ram_addr, 32'h24);
      tick();
    end
    wvalid    = 2'b10;
    wdata[1]  = 32'hBBBB_0002;
    #1;
    chk("wr_b_we", ram_we, 1'b1);
    chk("wr_b_addr", ram_addr, 32'h24);
    chk("wr_b_data", ram_wdata, 32'hBBBB_0002);
    tick();
    wvalid = '0;
    chk("wr_end_busy", busy, 1'b0);
    chk("wr_end_grant", grant, '0);

    // Read the written words back.
    cmd(0, 1'b0, 32'h20, 4'd1);
    #1;
    chk("rb_cmd_ready", cmd_ready, 2'b01);
    tick();
    cmd_valid = '0;
    #1;
    chk("rb_addr0", ram_addr, 32'h20);
    sb.push_back('{rv: 2'b01, d: 32'hAAAA_0001});
    tick();
    #1;
    chk("rb_addr1", ram_addr, 32'h24);
    sb.push_back('{rv: 2'b01, d: 32'hBBBB_0002});
    tick();
    tick();

    // Unaligned base and address wrap.
    read_burst("unal", 0, 32'h13, 0);
    read_burst("wrap", 0, 32'hFFFF_FFFC, 1);
    tick();

    // Write then read the same word.
    cmd(1, 1'b1, 32'h40, 4'd0);
    tick();
    cmd_valid = '0;
    wvalid[1] = 1'b1;
    wdata[1]  = 32'h5A5A_5A5A;
    #1;
    chk("wr40_we", ram_we, 1'b1);
    tick();
    wvalid = '0;
    cmd(0, 1'b0, 32'h40, 4'd0);
    tick();
    cmd_valid = '0;
    #1;
    chk("rd40_req", ram_req, 1'b1);
    sb.push_back('{rv: 2'b01, d: 32'h5A5A_5A5A});
    tick();
    tick();

    // Reset in the middle of a read burst drops the in-flight response.
    cmd(0, 1'b0, 32'h80, 4'd3);
    tick();
    cmd_valid = '0;
    #1;
    sb.push_back('{rv: 2'b01, d: pat(32'h80)});
    tick();
    rstn = 1'b0;
    tick();
    outputs_zero("midrst");
    rstn = 1'b1;
    tick();
    tick();

    // Continuous contention, len=0: req0 first after reset, then alternation with an idle gap.
    cmd(0, 1'b0, 32'h100, 4'd0);
    cmd(1, 1'b0, 32'h200, 4'd0);
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0]  exp_g;
      logic [AW-1:0] exp_a;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 32'h100 : 32'h200;
      #1;
      chk("rr_idle_busy", busy, 1'b0);
      chk("rr_cmd_ready", cmd_ready, exp_g);
      tick();
      #1;
      chk("rr_grant", grant, exp_g);
      chk("rr_addr", ram_addr, exp_a);
      chk("rr_busy_ready", cmd_ready, '0);
      sb.push_back('{rv: exp_g, d: pat(exp_a)});
      tick();
    end
    cmd_valid = '0;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
